lcd_hd44780_seq: RTL

- Sequencer for the on-board 2x16 HD44780 character LCD in 4-bit mode on VC707.
- After reset it runs the power-on initialisation, then accepts command/data bytes from two requesters (status logic, text writer) with round-robin arbitration.
- Each accepted byte is serialised as two E-strobed nibbles, followed by the instruction execution wait.
- Drives the LCD pins directly; replaces ad-hoc writes into the pin bus.

---
 rtl/lcd_pkg.sv | 73 +++++++
 rtl/lcd_hd44780_seq_if.sv | 14 +
 rtl/lcd_nibble_tx.sv | 73 +++++++
 rtl/lcd_hd44780_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 4-bit sequencer: state codes, default
// 200 MHz timing, the power-on init program and the slow-opcode set.
package lcd_pkg;

  localparam int unsigned DEF_T_PWR   = 3_000_000;
  localparam int unsigned DEF_T_INIT1 = 820_000;
  localparam int unsigned DEF_T_INIT2 = 20_000;
  localparam int unsigned DEF_T_SETUP = 10;
  localparam int unsigned DEF_T_E     = 50;
  localparam int unsigned DEF_T_NIB   = 200;
  localparam int unsigned DEF_T_CMD   = 8_000;
  localparam int unsigned DEF_T_CLR   = 328_000;

  // State codes. The nibble transmitter uses IDLE/SETUP/E_HIGH/E_LOW, the
  // sequencer uses PWR_WAIT/INIT/IDLE/BYTE/EXEC.
  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_INIT     = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_SETUP    = 3'd3;
  localparam logic [2:0] S_E_HIGH   = 3'd4;
  localparam logic [2:0] S_E_LOW    = 3'd5;
  localparam logic [2:0] S_EXEC     = 3'd6;
  localparam logic [2:0] S_BYTE     = 3'd7;

  // Wait selectors attached to each init nibble (NONE = next nibble follows).
  localparam logic [2:0] W_NONE  = 3'd0;
  localparam logic [2:0] W_INIT1 = 3'd1;
  localparam logic [2:0] W_INIT2 = 3'd2;
  localparam logic [2:0] W_CMD   = 3'd3;
  localparam logic [2:0] W_CLR   = 3'd4;

  // Clear display / return home need the long execution wait.
  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  typedef struct packed {
    logic [3:0] nib;
    logic [2:0] wsel;
  } init_step_t;

  localparam logic [3:0] INIT_LAST = 4'd11;

  // Power-on program: 3,3,3,2 wake-up nibbles, then 0x28, 0x0C, 0x06, 0x01.
  function automatic init_step_t init_step(input logic [3:0] idx);
    init_step_t s;
    case (idx)
      4'd0:    s = {4'h3, W_INIT1};
      4'd1:    s = {4'h3, W_INIT2};
      4'd2:    s = {4'h3, W_CMD};
      4'd3:    s = {4'h2, W_CMD};
      4'd4:    s = {4'h2, W_NONE};
      4'd5:    s = {4'h8, W_CMD};
      4'd6:    s = {4'h0, W_NONE};
      4'd7:    s = {4'hC, W_CMD};
      4'd8:    s = {4'h0, W_NONE};
      4'd9:    s = {4'h6, W_CMD};
      4'd10:   s = {4'h0, W_NONE};
      4'd11:   s = {4'h1, W_CLR};
      default: s = {4'h0, W_NONE};
    endcase
    return s;
  endfunction

  function automatic logic is_long_op(input logic rs, input logic [7:0] b);
    return !rs && (b == OP_CLEAR || b == OP_HOME || b == OP_HOME_ALT);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_seq_if.sv
// Requester-side byte port of the LCD sequencer.
// Handshake: a byte on lane i transfers on a clock edge where
// req_valid[i] & req_ready[i]; once valid is raised the requester holds it
// and its rs/data stable until that edge; ready never depends on anything
// but sequencer state, the round-robin pointer and valid.
interface lcd_hd44780_seq_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_ready;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_nibble_tx.sv
// One E-strobed nibble: SETUP (E=0), E_HIGH (E=1), E_LOW (E=0), with rs and
// data held for the whole nibble. A start accepted on the done cycle chains
// the next nibble without a gap.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_E     = DEF_T_E,
  parameter int unsigned T_NIB   = DEF_T_NIB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       start_rs,
  input  logic [3:0] start_nib,
  output logic       e,
  output logic       rs,
  output logic [3:0] nib,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned CW = $clog2(max2(max2(T_SETUP, T_E), T_NIB) + 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(1));
  assign done = (state == S_E_LOW) && last;

  // Phase counter: a loaded N keeps the phase for exactly N cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      e     <= 1'b0;
      rs    <= 1'b0;
      nib   <= 4'h0;
    end else if (start && (state == S_IDLE || done)) begin
      state <= S_SETUP;
      cnt   <= CW'(T_SETUP);
      e     <= 1'b0;
      rs    <= start_rs;
      nib   <= start_nib;
    end else begin
      case (state)
        S_SETUP: begin
          if (last) begin
            state <= S_E_HIGH;
            cnt   <= CW'(T_E);
            e     <= 1'b1;
          end else cnt <= cnt - CW'(1);
        end
        S_E_HIGH: begin
          if (last) begin
            state <= S_E_LOW;
            cnt   <= CW'(T_NIB);
            e     <= 1'b0;
          end else cnt <= cnt - CW'(1);
        end
        S_E_LOW: begin
          if (last) state <= S_IDLE;
          else cnt <= cnt - CW'(1);
        end
        default: begin
          state <= S_IDLE;
          e     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_hd44780_seq.sv
// HD44780 4-bit sequencer: power-on init, then round-robin byte service of
// two requesters, each byte sent as two nibbles plus an execution wait.
module lcd_hd44780_seq
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR   = DEF_T_PWR,
  parameter int unsigned T_INIT1 = DEF_T_INIT1,
  parameter int unsigned T_INIT2 = DEF_T_INIT2,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_E     = DEF_T_E,
  parameter int unsigned T_NIB   = DEF_T_NIB,
  parameter int unsigned T_CMD   = DEF_T_CMD,
  parameter int unsigned T_CLR   = DEF_T_CLR
) (
  input  logic             clk,
  input  logic             rst,
  lcd_hd44780_seq_if.slave req,
  output logic [2:0]       ctrl_lcd,
  output logic [3:0]       data_lcd,
  output logic             init_done,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int unsigned CW =
    $clog2(max2(max2(T_PWR, T_INIT1), max2(max2(T_INIT2, T_CMD), T_CLR)) + 1);

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    init_idx, idx_n;
  logic          lo_phase, lo_n, done_n;
  logic          ptr, grant_vld, grant_idx, grant_rs, accept;
  logic [7:0]    byte_q, grant_byte;
  logic          rs_q;
  logic          start, start_rs, nib_done, lcd_e, lcd_rs;
  logic [3:0]    start_nib, lcd_nib;
  logic [2:0]    nib_state;
  init_step_t    step, nstep;

  function automatic logic [CW-1:0] wait_len(input logic [2:0] sel);
    case (sel)
      W_INIT1: return CW'(T_INIT1);
      W_INIT2: return CW'(T_INIT2);
      W_CLR:   return CW'(T_CLR);
      default: return CW'(T_CMD);
    endcase
  endfunction

  // Round-robin grant: the pointer holder wins, otherwise the other lane.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr;
    if (req.req_valid[ptr]) begin
      grant_vld = 1'b1;
      grant_idx = ptr;
    end else if (req.req_valid[~ptr]) begin
      grant_vld = 1'b1;
      grant_idx = ~ptr;
    end
  end

  assign grant_byte    = req.req_data[{grant_idx, 3'b000} +: 8];
  assign grant_rs      = req.req_rs[grant_idx];
  assign req.req_ready = (state == S_IDLE && init_done && grant_vld) ? (2'b01 << grant_idx) : 2'b00;
  assign accept        = |(req.req_valid & req.req_ready);

  // Sequencer next state; starts are issued on the cycle the transmitter
  // frees up so phases run back to back.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = init_idx;
    lo_n      = lo_phase;
    done_n    = init_done;
    start     = 1'b0;
    start_rs  = 1'b0;
    start_nib = 4'h0;
    step      = init_step(init_idx);
    nstep     = init_step(init_idx + 4'd1);
    case (state)
      S_PWR_WAIT: begin
        if (cnt == CW'(1)) begin
          start     = 1'b1;
          start_nib = step.nib;
          state_n   = S_INIT;
        end else cnt_n = cnt - CW'(1);
      end
      S_INIT: begin
        if (nib_done) begin
          if (step.wsel == W_NONE) begin
            start     = 1'b1;
            start_nib = nstep.nib;
            idx_n     = init_idx + 4'd1;
          end else begin
            state_n = S_EXEC;
            cnt_n   = wait_len(step.wsel);
          end
        end
      end
      S_EXEC: begin
        if (cnt == CW'(1)) begin
          if (!init_done && init_idx != INIT_LAST) begin
            start     = 1'b1;
            start_nib = nstep.nib;
            idx_n     = init_idx + 4'd1;
            state_n   = S_INIT;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else cnt_n = cnt - CW'(1);
      end
      S_IDLE: begin
        if (accept) begin
          start     = 1'b1;
          start_rs  = grant_rs;
          start_nib = grant_byte[7:4];
          lo_n      = 1'b0;
          state_n   = S_BYTE;
        end
      end
      S_BYTE: begin
        if (nib_done) begin
          if (!lo_phase) begin
            start     = 1'b1;
            start_rs  = rs_q;
            start_nib = byte_q[3:0];
            lo_n      = 1'b1;
          end else begin
            state_n = S_EXEC;
            cnt_n   = is_long_op(rs_q, byte_q) ? CW'(T_CLR) : CW'(T_CMD);
          end
        end
      end
      default: state_n = S_PWR_WAIT;
    endcase
  end

  // Sequencer registers; reset restarts the whole power-on program.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_PWR_WAIT;
      cnt       <= CW'(T_PWR);
      init_idx  <= 4'd0;
      lo_phase  <= 1'b0;
      init_done <= 1'b0;
      ptr       <= 1'b0;
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      init_idx  <= idx_n;
      lo_phase  <= lo_n;
      init_done <= done_n;
      if (accept) begin
        byte_q <= grant_byte;
        rs_q   <= grant_rs;
        ptr    <= ~grant_idx;
      end
    end
  end

  lcd_nibble_tx #(.T_SETUP(T_SETUP), .T_E(T_E), .T_NIB(T_NIB)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_rs  (start_rs),
    .start_nib (start_nib),
    .e         (lcd_e),
    .rs        (lcd_rs),
    .nib       (lcd_nib),
    .done      (nib_done),
    .state     (nib_state)
  );

  assign ctrl_lcd  = {lcd_rs, 1'b0, lcd_e};
  assign data_lcd  = lcd_nib;
  assign busy      = (state != S_IDLE);
  assign dbg_state = (state == S_INIT || state == S_BYTE) ? nib_state : state;

endmodule
